// File: rtl/lfsr_stream_ctrl.sv
// lfsr_stream_ctrl: sequences a shared LFSR core and hands one fresh word per grant to two requesters
module lfsr_stream_ctrl #(
    parameter int n    = 4,
    parameter int WARM = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   req,
    output logic [n-1:0] rdata,
    output logic [1:0]   rvalid,
    output logic         ready,
    output logic         busy,
    output logic         lfsr_clr,
    output logic         lfsr_ena,
    input  logic [n-1:0] lfsr_random
);
    localparam int CW = (WARM > 0) ? $clog2(WARM + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_WARM, S_READY, S_STEP, S_CAPT} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           win_q, win_d;
    logic           last_q, last_d;
    logic [n-1:0]   rdata_q, rdata_d;
    logic [1:0]     rvalid_q, rvalid_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;

    // next-state, arbitration and capture; status outputs follow the next state so they are registered
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        last_d   = last_q;
        rdata_d  = rdata_q;
        rvalid_d = 2'b00;
        case (state_q)
            S_IDLE:  state_d = start ? S_CLR : S_IDLE;
            S_CLR: begin
                state_d = (WARM > 0) ? S_WARM : S_READY;
                cnt_d   = CW'(WARM);
            end
            S_WARM: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? S_READY : S_WARM;
            end
            S_READY: begin
                if (start) begin
                    state_d = S_CLR;
                end else if (|req) begin
                    win_d   = (req == 2'b11) ? ~last_q : req[1];
                    state_d = S_STEP;
                end
            end
            S_STEP:  state_d = S_CAPT;
            S_CAPT: begin
                rdata_d  = lfsr_random;
                rvalid_d = win_q ? 2'b10 : 2'b01;
                last_d   = win_q;
                state_d  = S_READY;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_READY);
        busy_d  = (state_d == S_CLR) || (state_d == S_WARM) || (state_d == S_STEP) || (state_d == S_CAPT);
    end

    // state and registered outputs; last_served resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            win_q    <= 1'b0;
            last_q   <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            last_q   <= last_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign lfsr_clr = (state_q == S_CLR);
    assign lfsr_ena = (state_q == S_WARM) || (state_q == S_STEP);
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
endmodule
